// File: rtl/controle_partida.sv
// Match sequencer for the two-paddle game: round flow, scores, object
// reset / ball enable, and per-player cooldown-gated smash triggers.
module controle_partida #(
  parameter int PONTOS_VITORIA  = 5,
  parameter int CICLOS_SAQUE    = 50000000,
  parameter int CICLOS_PONTO    = 25000000,
  parameter int CICLOS_COOLDOWN = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_n,
  input  logic       porradao_n_p1,
  input  logic       porradao_n_p2,
  input  logic       gol_esq,
  input  logic       gol_dir,
  output logic       reset_objetos,
  output logic       bola_ativa,
  output logic       porradao_out_n_p1,
  output logic       porradao_out_n_p2,
  output logic [3:0] placar_p1,
  output logic [3:0] placar_p2,
  output logic [2:0] estado,
  output logic [1:0] vencedor,
  output logic       saque_dir
);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    SAQUE  = 3'd1,
    JOGO   = 3'd2,
    PONTO  = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam logic [3:0]  VITORIA   = 4'(PONTOS_VITORIA);
  localparam logic [31:0] FIM_SAQUE = 32'(CICLOS_SAQUE - 1);
  localparam logic [31:0] FIM_PONTO = 32'(CICLOS_PONTO - 1);
  localparam logic [31:0] CD_CARGA  = 32'(CICLOS_COOLDOWN);

  estado_t     st;
  logic [31:0] cnt;
  logic [31:0] cd_p1;
  logic [31:0] cd_p2;
  logic        start_n_p0;
  logic        smash1_n_p0;
  logic        smash2_n_p0;
  logic        start_edge;
  logic        smash1_edge;
  logic        smash2_edge;
  logic [3:0]  p1_inc;
  logic [3:0]  p2_inc;

  // Falling edge = button was released last cycle and is pressed now.
  assign start_edge  = start_n_p0  & ~start_n;
  assign smash1_edge = smash1_n_p0 & ~porradao_n_p1;
  assign smash2_edge = smash2_n_p0 & ~porradao_n_p2;

  assign p1_inc = placar_p1 + 4'd1;
  assign p2_inc = placar_p2 + 4'd1;
  assign estado = st;

  // Previous-cycle button levels; loaded as released so reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_n_p0  <= 1'b1;
      smash1_n_p0 <= 1'b1;
      smash2_n_p0 <= 1'b1;
    end else begin
      start_n_p0  <= start_n;
      smash1_n_p0 <= porradao_n_p1;
      smash2_n_p0 <= porradao_n_p2;
    end
  end

  // Round sequencer: state, shared round counter, scores and registered scene controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= OCIOSO;
      cnt           <= '0;
      placar_p1     <= '0;
      placar_p2     <= '0;
      vencedor      <= 2'd0;
      saque_dir     <= 1'b0;
      reset_objetos <= 1'b1;
      bola_ativa    <= 1'b0;
    end else begin
      case (st)
        OCIOSO, FIM: begin
          if (start_edge) begin
            st            <= SAQUE;
            cnt           <= '0;
            placar_p1     <= '0;
            placar_p2     <= '0;
            vencedor      <= 2'd0;
            saque_dir     <= 1'b0;
            reset_objetos <= 1'b1;
            bola_ativa    <= 1'b0;
          end
        end
        SAQUE: begin
          if (cnt == FIM_SAQUE) begin
            st            <= JOGO;
            cnt           <= '0;
            reset_objetos <= 1'b0;
            bola_ativa    <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        JOGO: begin
          // Left-edge goal takes priority when both edges report in one cycle.
          if (gol_esq) begin
            placar_p2  <= p2_inc;
            saque_dir  <= 1'b0;
            cnt        <= '0;
            bola_ativa <= 1'b0;
            if (p2_inc == VITORIA) begin
              st            <= FIM;
              vencedor      <= 2'd2;
              reset_objetos <= 1'b1;
            end else begin
              st            <= PONTO;
              reset_objetos <= 1'b0;
            end
          end else if (gol_dir) begin
            placar_p1  <= p1_inc;
            saque_dir  <= 1'b1;
            cnt        <= '0;
            bola_ativa <= 1'b0;
            if (p1_inc == VITORIA) begin
              st            <= FIM;
              vencedor      <= 2'd1;
              reset_objetos <= 1'b1;
            end else begin
              st            <= PONTO;
              reset_objetos <= 1'b0;
            end
          end
        end
        PONTO: begin
          if (cnt == FIM_PONTO) begin
            st            <= SAQUE;
            cnt           <= '0;
            reset_objetos <= 1'b1;
            bola_ativa    <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          st            <= OCIOSO;
          cnt           <= '0;
          reset_objetos <= 1'b1;
          bola_ativa    <= 1'b0;
        end
      endcase
    end
  end

  // Player 1 smash gate: one-cycle low pulse per accepted edge, then cooldown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cd_p1             <= '0;
      porradao_out_n_p1 <= 1'b1;
    end else if (st != JOGO) begin
      cd_p1             <= '0;
      porradao_out_n_p1 <= 1'b1;
    end else if (smash1_edge && (cd_p1 == '0)) begin
      cd_p1             <= CD_CARGA;
      porradao_out_n_p1 <= 1'b0;
    end else begin
      porradao_out_n_p1 <= 1'b1;
      if (cd_p1 != '0) cd_p1 <= cd_p1 - 32'd1;
    end
  end

  // Player 2 smash gate: independent copy of the player 1 gate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cd_p2             <= '0;
      porradao_out_n_p2 <= 1'b1;
    end else if (st != JOGO) begin
      cd_p2             <= '0;
      porradao_out_n_p2 <= 1'b1;
    end else if (smash2_edge && (cd_p2 == '0)) begin
      cd_p2             <= CD_CARGA;
      porradao_out_n_p2 <= 1'b0;
    end else begin
      porradao_out_n_p2 <= 1'b1;
      if (cd_p2 != '0) cd_p2 <= cd_p2 - 32'd1;
    end
  end

endmodule

// File: doc/controle_partida.md
Name: controle_partida

Overview:
Match sequencer for the two-paddle game. It owns the round flow (idle, serve countdown, play, point pause, game over) and keeps both scores. It drives the object-reset and ball-enable lines to the paddle and ball blocks. It gates each player's raw smash button into a one-cycle, cooldown-limited, active-low trigger for that player's paddle.

Parameters:
PONTOS_VITORIA, 5, score that ends the match (1..15)
CICLOS_SAQUE, 50000000, serve countdown length in clk cycles (1 s at 50 MHz)
CICLOS_PONTO, 25000000, freeze length after a point
CICLOS_COOLDOWN, 12500000, minimum spacing between accepted smash triggers per player; must be >= 10000000 (paddle smash duration)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start_n  input  1  start button, active-low
porradao_n_p1  input  1  raw smash button, player 1 (left), active-low
porradao_n_p2  input  1  raw smash button, player 2 (right), active-low
gol_esq  input  1  one-cycle pulse: ball crossed left edge (point to p2)
gol_dir  input  1  one-cycle pulse: ball crossed right edge (point to p1)
reset_objetos  output  1  high = hold paddles/ball at initial position
bola_ativa  output  1  high = ball may move
porradao_out_n_p1  output  1  gated smash trigger to paddle 1, active-low
porradao_out_n_p2  output  1  gated smash trigger to paddle 2, active-low
placar_p1  output  4  player 1 score
placar_p2  output  4  player 2 score
estado  output  3  current state code
vencedor  output  2  0 none, 1 p1, 2 p2
saque_dir  output  1  serve direction: 0 toward p1 (left), 1 toward p2 (right)

Behaviour:
- Reset (async, immediate, including mid-match):
  - estado=OCIOSO, scores 0, vencedor 0, saque_dir 0.
  - reset_objetos 1, bola_ativa 0, both porradao_out_n 1.
  - All counters and edge-detect registers cleared; edge registers load 1 (buttons released).
- Button edges: start_n, porradao_n_p1 and porradao_n_p2 are each registered once. Edge = previous 1 and current 0. Holding a button never produces a second edge.
- All outputs are registered. A 32-bit counter cnt is shared by the round states and cleared on every state change.
- States (estado code):
  - OCIOSO (0): reset_objetos 1, bola_ativa 0. start edge -> SAQUE; scores, vencedor and saque_dir cleared.
  - SAQUE (1): reset_objetos 1, bola_ativa 0. cnt increments; at cnt==CICLOS_SAQUE-1 -> JOGO. Duration is exactly CICLOS_SAQUE cycles.
  - JOGO (2): reset_objetos 0, bola_ativa 1.
    - gol_esq: placar_p2+1, saque_dir<=0 (serve toward the player who conceded).
    - gol_dir: placar_p1+1, saque_dir<=1.
    - Both pulses in the same cycle: gol_esq wins, gol_dir is dropped.
    - If the incremented score == PONTOS_VITORIA -> FIM with vencedor set; otherwise -> PONTO.
  - PONTO (3): reset_objetos 0, bola_ativa 0 (frozen scene). At cnt==CICLOS_PONTO-1 -> SAQUE.
  - FIM (4): reset_objetos 1, bola_ativa 0; scores and vencedor held. start edge -> SAQUE with scores, vencedor and saque_dir cleared.
- gol_esq and gol_dir are ignored outside JOGO. Scores never exceed PONTOS_VITORIA.
- Smash gating, per player, independent:
  - A 32-bit cooldown counter cd is active only in JOGO.
  - Smash edge while cd==0: porradao_out_n goes low for exactly one cycle, on the clock after the edge is detected. cd loads CICLOS_COOLDOWN.
  - cd decrements to 0. Edges while cd!=0 are dropped, not queued.
  - Outside JOGO: porradao_out_n held 1 and cd forced to 0.
  - Entering JOGO with a button already held does not fire; a new press is required.
  - Both players firing in the same cycle: both outputs pulse.
- A start edge in SAQUE, JOGO or PONTO is ignored.

Test Plan:
(bench params: PONTOS_VITORIA=2, CICLOS_SAQUE=4, CICLOS_PONTO=3, CICLOS_COOLDOWN=6)
1. Reset, then pulse start_n low 1 cycle -> estado 1 with reset_objetos=1 for exactly 4 cycles, then estado 2, bola_ativa=1, reset_objetos=0.
2. In JOGO, gol_dir pulse -> placar_p1=1, saque_dir=1, estado 3 for 3 cycles, then SAQUE (4 cycles), then JOGO. Second gol_dir -> placar_p1=2, vencedor=1, estado 4, reset_objetos=1.
3. In JOGO, gol_esq and gol_dir asserted together -> only placar_p2 increments (0->1); placar_p1 unchanged.
4. In JOGO, hold porradao_n_p1 low 20 cycles -> porradao_out_n_p1 low exactly 1 cycle, one cycle after the edge is detected. Release and press at cd=3 -> no pulse. Press after 6 cycles -> pulse.
5. porradao_n_p2 pressed in SAQUE and in FIM -> porradao_out_n_p2 stays 1; gol pulses in PONTO -> scores unchanged.
6. Assert reset mid-JOGO with scores 1/1 -> same cycle: estado 0, scores 0, bola_ativa 0, reset_objetos 1; in FIM, start edge -> estado 1 with scores cleared.
